pll_rst_ctrl: RTL
=================

PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_rst is held high per reset attempt (minimum 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles to wait for lock after pll_rst is released (minimum 2).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before ready (minimum 1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: lock timeouts tolerated before fault (0..15).
REQ-005 SHALL have port refclk, input, 1: free-running reference clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port pll_locked, input, 1: PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL have port relock_req, input, 1: single-cycle request to re-lock the PLL.
REQ-009 SHALL have port pll_rst, output, 1: drives the PLL reset input.
REQ-010 SHALL have port ready, output, 1: PLL output clock is locked and stable.
REQ-011 SHALL have port fault, output, 1: retries are exhausted.
REQ-012 SHALL have port retry_cnt, output, 4: timeouts since the last entry to RUN.
REQ-013 SHALL have port loss_cnt, output, 8: lock losses seen while in RUN, saturating at 255.

Function
REQ-014 SHALL synchronize pll_locked through two flops; locked_s is the second flop, and only locked_s is used by the FSM.
REQ-015 SHALL implement the states ASSERT_RST, WAIT_LOCK, STABLE, RUN and FAULT, with a single shared cycle counter cnt that is cleared on every state change.
REQ-016 ASSERT_RST SHALL hold pll_rst=1 and, at the edge where cnt==RST_CYCLES-1, transition to WAIT_LOCK.
REQ-017 WAIT_LOCK SHALL hold pll_rst=0 and transition as follows:
- locked_s=1: go to STABLE.
- otherwise, at cnt==LOCK_TIMEOUT-1 with retry_cnt==MAX_RETRIES: go to FAULT.
- otherwise, at cnt==LOCK_TIMEOUT-1: increment retry_cnt and go to ASSERT_RST.
REQ-018 STABLE SHALL transition as follows:
- locked_s=0: return to WAIT_LOCK with cnt cleared; this SHALL NOT count as a retry and SHALL NOT reset the timeout budget beyond clearing cnt.
- locked_s=1 at cnt==STABLE_CYCLES-1: go to RUN.
REQ-019 Entering RUN SHALL clear retry_cnt.
REQ-020 RUN SHALL transition as follows:
- locked_s=0: go to ASSERT_RST and increment loss_cnt (saturating).
- else relock_req=1: go to ASSERT_RST without changing loss_cnt.
- If both occur in the same cycle, loss_cnt increments exactly once.
REQ-021 relock_req SHALL be ignored in every state other than RUN.
REQ-022 FAULT SHALL hold pll_rst=1 and fault=1 and be exited only by rst.
REQ-023 All outputs SHALL be registered Moore decodes of the state register:
- pll_rst = (state is ASSERT_RST or FAULT).
- ready = (state is RUN).
- fault = (state is FAULT).
REQ-024 ready SHALL never be high in the same cycle as pll_rst.
REQ-025 Counter widths SHALL be sized by $clog2 of the largest count parameter, with no wrap-around reachable.

Reset
REQ-026 While rst=1, the block SHALL set state=ASSERT_RST, cnt=0, both sync flops=0, retry_cnt=0 and loss_cnt=0.
REQ-027 Reset output values SHALL be pll_rst=1, ready=0 and fault=0.
REQ-028 rst asserted mid-operation in any state, including FAULT, SHALL restart the full sequence from ASSERT_RST on the next edge.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-029 Normal lock:
- Stimulus: release rst; pll_locked=1 from cycle 10.
- Response: pll_rst high for exactly 4 cycles; ready rises 10 edges after the first edge sampling pll_locked=1; retry_cnt=0.
REQ-030 Lock glitch during STABLE:
- Stimulus: pll_locked drops for 1 cycle at STABLE cnt=5.
- Response: the FSM returns to WAIT_LOCK, then requires a full 8 stable cycles; retry_cnt is unchanged; pll_rst is not re-asserted.
REQ-031 Timeout and fault:
- Stimulus: pll_locked held at 0.
- Response: three 4-cycle pll_rst pulses spaced by 32-cycle waits; retry_cnt goes 1, then 2; fault=1 after the third timeout; pll_rst is held at 1; relock_req is ignored.
REQ-032 Loss in RUN:
- Stimulus: drop pll_locked while ready=1.
- Response: ready falls 3 edges later; loss_cnt=1; pll_rst pulses for 4 cycles; re-locking restores ready; forcing 300 losses leaves loss_cnt=255.
REQ-033 relock_req:
- Stimulus: pulse relock_req in RUN, and separately in STABLE.
- Response: the RUN pulse gives ready=0 and a pll_rst pulse with loss_cnt unchanged; the STABLE pulse has no effect.
REQ-034 Mid-operation reset:
- Stimulus: assert rst during FAULT, and separately during WAIT_LOCK at cnt=20.
- Response: each gives fault=0, retry_cnt=0 and pll_rst=1 on the next cycle, followed by a fresh 4-cycle reset pulse.

Source files
------------

// File: rtl/pll_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_rst_ctrl
// Description : PLL reset sequencer. Pulses the PLL reset, waits for lock
//               with a timeout and bounded retries, then requires a run of
//               consecutive stable lock cycles before declaring ready. Lock
//               loss or a relock request while running restarts the sequence.
//               All logic is on the rising edge of refclk.
// Ports       : refclk     - free-running reference clock
//               rst        - synchronous active-high reset
//               pll_locked - PLL lock indicator (asynchronous to refclk)
//               relock_req - single-cycle request to re-lock (RUN state only)
//               pll_rst    - PLL reset drive
//               ready      - PLL locked and stable
//               fault      - retries exhausted; cleared only by rst
//               retry_cnt  - lock timeouts since the last entry to RUN
//               loss_cnt   - lock losses seen in RUN, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module pll_rst_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    // The shared counter only ever counts up to (largest count - 1), so
    // $clog2 of the largest parameter is enough bits.
    localparam int c_MAX_A   = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int c_MAX_CNT = (LOCK_TIMEOUT > c_MAX_A) ? LOCK_TIMEOUT : c_MAX_A;
    localparam int c_CNT_W   = (c_MAX_CNT > 1) ? $clog2(c_MAX_CNT) : 1;

    localparam logic [c_CNT_W-1:0] c_RST_LAST    = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST   = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [3:0]         c_RETRY_MAX   = 4'(MAX_RETRIES);

    localparam logic [2:0] c_ST_ASSERT_RST = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] c_ST_STABLE     = 3'd2;
    localparam logic [2:0] c_ST_RUN        = 3'd3;
    localparam logic [2:0] c_ST_FAULT      = 3'd4;

    logic               r_sync1;
    logic               r_locked_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_retry_cnt;
    logic [7:0]         r_loss_cnt;

    logic [2:0]         w_state_nxt;
    logic               w_retry_inc;
    logic               w_retry_clr;
    logic               w_loss_inc;

    // Two-flop synchronizer; only r_locked_s feeds the FSM.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= pll_locked;
            r_locked_s <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        w_loss_inc  = 1'b0;
        case (r_state)
            c_ST_ASSERT_RST: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end
            end
            c_ST_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_nxt = c_ST_STABLE;
                end else if (r_cnt == c_LOCK_LAST) begin
                    if (r_retry_cnt == c_RETRY_MAX) begin
                        w_state_nxt = c_ST_FAULT;
                    end else begin
                        w_state_nxt = c_ST_ASSERT_RST;
                        w_retry_inc = 1'b1;
                    end
                end
            end
            c_ST_STABLE: begin
                // A lock dropout here goes back to waiting without costing
                // a retry; the PLL is not reset again.
                if (!r_locked_s) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_retry_clr = 1'b1;
                end
            end
            c_ST_RUN: begin
                // Lock loss takes priority so a coincident relock request
                // still counts the loss exactly once.
                if (!r_locked_s) begin
                    w_state_nxt = c_ST_ASSERT_RST;
                    w_loss_inc  = 1'b1;
                end else if (relock_req) begin
                    w_state_nxt = c_ST_ASSERT_RST;
                end
            end
            c_ST_FAULT: begin
                w_state_nxt = c_ST_FAULT;
            end
            default: begin
                w_state_nxt = c_ST_ASSERT_RST;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state     <= c_ST_ASSERT_RST;
            r_cnt       <= '0;
            r_retry_cnt <= 4'd0;
            r_loss_cnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            // Counting states always leave at their last count, so r_cnt
            // cannot wrap. RUN and FAULT keep it parked at zero.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == c_ST_ASSERT_RST) || (r_state == c_ST_WAIT_LOCK) ||
                         (r_state == c_ST_STABLE)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (w_retry_clr) begin
                r_retry_cnt <= 4'd0;
            end else if (w_retry_inc) begin
                r_retry_cnt <= r_retry_cnt + 4'd1;
            end

            if (w_loss_inc && (r_loss_cnt != 8'hFF)) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end
    end

    // Moore decodes of the state register; ready and pll_rst are decoded
    // from disjoint states so they can never be high together.
    assign pll_rst   = (r_state == c_ST_ASSERT_RST) || (r_state == c_ST_FAULT);
    assign ready     = (r_state == c_ST_RUN);
    assign fault     = (r_state == c_ST_FAULT);
    assign retry_cnt = r_retry_cnt;
    assign loss_cnt  = r_loss_cnt;

endmodule
`default_nettype wire
